// File: rtl/ila_frontend_pkg.sv
// Shared types, defaults and helpers for the ILA probe front end.
// Build option ILA_FRONTEND_CKSUM_EN enables the trailing XOR checksum byte.
package ila_frontend_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CKSUM   = 3'd3,
        DONE    = 3'd4
    } fe_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Idle counter width; covers the full 1..65535 TIMEOUT range.
    localparam int IDLE_W = 16;

    // Counters up to 64 bits wide share this helper; callers zero-extend and truncate.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value == max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/ila_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// Part of the ILA probe front end (ILA_FRONTEND_CKSUM_EN does not affect this file).
module ila_sat_counter
    import ila_frontend_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= CNT_W'(sat_inc(64'(count), 64'(CNT_MAX)));
        end
    end

endmodule

// File: rtl/ila_probe_frontend.sv
// Frame tracker feeding ChipWatcher probe0/probe1 with clean registered probes.
// ILA_FRONTEND_CKSUM_EN defined: frames end with an XOR checksum byte that is verified.
module ila_probe_frontend
    import ila_frontend_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 1024,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             probe0,
    output logic [7:0]       probe1,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output fe_state_t        fsm_state
);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

`ifdef ILA_FRONTEND_CKSUM_EN
    localparam fe_state_t AFTER_PAYLOAD = CKSUM;
    logic [7:0] cksum;
`else
    localparam fe_state_t AFTER_PAYLOAD = DONE;
`endif

    fe_state_t         state;
    logic [7:0]        remain;
    logic [IDLE_W-1:0] idle;
    logic              in_frame_wait;
    logic              timeout_hit;
    logic              ck_bad;
    logic              ok_evt;
    logic              err_evt;
    logic              sync_seen;

    // Events are combinational so the pulse registers and counters update on the same edge.
    always_comb begin
        in_frame_wait = (state == LEN) || (state == PAYLOAD) || (state == CKSUM);
        timeout_hit   = in_frame_wait && !in_valid && (idle == IDLE_LAST);
        ck_bad        = 1'b0;
`ifdef ILA_FRONTEND_CKSUM_EN
        ck_bad        = (state == CKSUM) && in_valid && (in_data != cksum);
`endif
        ok_evt        = (state == DONE);
        err_evt       = timeout_hit || ck_bad;
        sync_seen     = in_valid && (in_data == SYNC_BYTE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            remain    <= 8'h00;
            idle      <= '0;
`ifdef ILA_FRONTEND_CKSUM_EN
            cksum     <= 8'h00;
`endif
            probe0    <= 1'b0;
            probe1    <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= ok_evt;
            frame_err <= err_evt;
            if (in_valid) begin
                probe1 <= in_data;
            end
            if (in_frame_wait && !in_valid) begin
                idle <= idle + 1'b1;
            end else begin
                idle <= '0;
            end

            case (state)
                // DONE behaves like HUNT for the incoming byte so back-to-back frames work.
                HUNT, DONE: begin
                    if (sync_seen) begin
                        state  <= LEN;
                        probe0 <= 1'b1;
                    end else begin
                        state  <= HUNT;
                        probe0 <= 1'b0;
                    end
                end
                LEN: begin
                    if (in_valid) begin
                        remain <= in_data;
`ifdef ILA_FRONTEND_CKSUM_EN
                        cksum  <= 8'h00;
`endif
                        state  <= (in_data != 8'h00) ? PAYLOAD : AFTER_PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_valid) begin
`ifdef ILA_FRONTEND_CKSUM_EN
                        cksum  <= cksum ^ in_data;
`endif
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            state <= AFTER_PAYLOAD;
                        end
                    end
                end
`ifdef ILA_FRONTEND_CKSUM_EN
                CKSUM: begin
                    if (in_valid) begin
                        if (ck_bad) begin
                            state  <= HUNT;
                            probe0 <= 1'b0;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
`endif
                default: begin
                    state  <= HUNT;
                    probe0 <= 1'b0;
                end
            endcase

            if (timeout_hit) begin
                state  <= HUNT;
                probe0 <= 1'b0;
                idle   <= '0;
            end
        end
    end

    assign fsm_state = state;

    ila_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ok_evt),
        .count (ok_cnt)
    );

    ila_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_evt),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_ila_probe_frontend.sv
// Bench for ila_probe_frontend: builds a byte schedule of frames and predicts probe/pulse/count outputs per edge.
// Works with or without ILA_FRONTEND_CKSUM_EN defined.
module tb_ila_probe_frontend;
    import ila_frontend_pkg::*;

    localparam int T    = 8;
    localparam int MAXC = 4000;
`ifdef ILA_FRONTEND_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;

    logic        probe0, frame_ok, frame_err;
    logic [7:0]  probe1;
    logic [15:0] ok_cnt, err_cnt;
    fe_state_t   fsm_state;

    logic        probe0_b, frame_ok_b, frame_err_b;
    logic [7:0]  probe1_b;
    logic [1:0]  ok_cnt_b, err_cnt_b;
    fe_state_t   fsm_state_b;

    always #5 clk = ~clk;

    ila_probe_frontend #(.SYNC_BYTE(8'hA5), .TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .probe0(probe0), .probe1(probe1), .frame_ok(frame_ok), .frame_err(frame_err),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .fsm_state(fsm_state)
    );

    // Narrow-counter copy on the same stream to exercise saturation.
    ila_probe_frontend #(.SYNC_BYTE(8'hA5), .TIMEOUT(T), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .probe0(probe0_b), .probe1(probe1_b), .frame_ok(frame_ok_b), .frame_err(frame_err_b),
        .ok_cnt(ok_cnt_b), .err_cnt(err_cnt_b), .fsm_state(fsm_state_b)
    );

    logic       s_v  [MAXC];
    logic [7:0] s_d  [MAXC];
    bit         e_p0 [MAXC];
    bit         e_ok [MAXC];
    bit         e_err[MAXC];
    int         n_sched = 0;
    logic [7:0] pay_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at step %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [7:0] d);
        if (n_sched < MAXC) begin
            s_v[n_sched] = v;
            s_d[n_sched] = d;
            n_sched++;
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 8'($urandom));
    endtask

    task automatic push_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            push(($urandom_range(0, 3) != 0), b);
        end
    endtask

    task automatic mark_p0(input int a, input int b);
        for (int i = a; i <= b; i++) if (i < MAXC) e_p0[i] = 1'b1;
    endtask

    // mode 0: good frame, 1: corrupted checksum (xor'd with bad_xor), 2: stall after cut bytes
    task automatic send_frame(input int mode, input int cut, input int maxgap, input logic [7:0] bad_xor);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int s, last;
        bytes = {};
        x = 8'h00;
        bytes.push_back(8'hA5);
        bytes.push_back(8'(pay_q.size()));
        foreach (pay_q[i]) begin
            bytes.push_back(pay_q[i]);
            x ^= pay_q[i];
        end
        if (CK) bytes.push_back((mode == 1) ? (x ^ bad_xor) : x);
        s = n_sched;
        last = s;
        for (int i = 0; i < bytes.size(); i++) begin
            if (mode == 2 && i == cut) break;
            if (i > 0 && maxgap > 0) push_idle($urandom_range(0, maxgap));
            last = n_sched;
            push(1'b1, bytes[i]);
        end
        if (mode == 0) begin
            mark_p0(s, last);
            if (last + 1 < MAXC) e_ok[last + 1] = 1'b1;
        end else if (mode == 1) begin
            mark_p0(s, last - 1);
            if (last < MAXC) e_err[last] = 1'b1;
        end else begin
            push_idle(T);
            mark_p0(s, last + T - 1);
            if (last + T < MAXC) e_err[last + T] = 1'b1;
        end
    endtask

    initial begin
        int okc, errc, len, mode, r, total, nb;
        logic [7:0] lastb;
        logic [7:0] tail[$];

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_probe0", 32'(probe0), 32'd0);
        check("rst_probe1", 32'(probe1), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(HUNT));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed frames
        push_junk(2);
        pay_q = '{8'h11, 8'h22};
        send_frame(0, 0, 0, 8'h00);
        push_idle(2);
        if (CK) begin
            pay_q = '{8'h7F};
            send_frame(1, 0, 0, 8'h7F);
            push_idle(2);
        end
        pay_q = {};
        send_frame(0, 0, 0, 8'h00);
        push_idle(1);
        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(2, 3, 0, 8'h00);
        pay_q = '{8'h01, 8'hA5, 8'h03};
        send_frame(0, 0, 0, 8'h00);
        send_frame(0, 0, 0, 8'h00);
        pay_q = '{8'h5C};
        send_frame(0, 0, T - 1, 8'h00);
        push_junk(3);

        // Randomized frames
        for (int f = 0; f < 45; f++) begin
            len = (f == 20) ? 200 : $urandom_range(0, 6);
            pay_q = {};
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? (CK ? 1 : 0) : 2;
            total = 2 + len + (CK ? 1 : 0);
            send_frame(mode, $urandom_range(1, total - 1),
                       ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(0, 2),
                       8'($urandom_range(1, 255)));
            push_junk($urandom_range(0, 3));
        end
        push_idle(4);

        // Replay schedule and compare every edge
        okc = 0;
        errc = 0;
        lastb = 8'h00;
        for (int n = 0; n < n_sched; n++) begin
            @(negedge clk);
            in_valid = s_v[n];
            in_data  = s_d[n];
            @(posedge clk);
            #1;
            cyc = n;
            if (s_v[n]) lastb = s_d[n];
            okc  += int'(e_ok[n]);
            errc += int'(e_err[n]);
            check("probe0", 32'(probe0), 32'(e_p0[n]));
            check("probe1", 32'(probe1), 32'(lastb));
            check("frame_ok", 32'(frame_ok), 32'(e_ok[n]));
            check("frame_err", 32'(frame_err), 32'(e_err[n]));
            check("ok_cnt", 32'(ok_cnt), 32'(okc));
            check("err_cnt", 32'(err_cnt), 32'(errc));
            check("ok_cnt_sat", 32'(ok_cnt_b), 32'((okc > 3) ? 3 : okc));
            check("err_cnt_sat", 32'(err_cnt_b), 32'((errc > 3) ? 3 : errc));
        end

        // Reset in the middle of a payload
        cyc = -1;
        tail = '{8'hA5, 8'h05, 8'h01, 8'h02};
        foreach (tail[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tail[i];
        end
        @(posedge clk);
        #1;
        check("mid_state", 32'(fsm_state), 32'(PAYLOAD));
        check("mid_probe0", 32'(probe0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_probe0", 32'(probe0), 32'd0);
        check("arst_probe1", 32'(probe1), 32'd0);
        check("arst_ok_cnt", 32'(ok_cnt), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_frame_ok", 32'(frame_ok), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        check("arst_state", 32'(fsm_state), 32'(HUNT));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        tail = '{8'h11, 8'h22, 8'hA4, 8'h00};
        foreach (tail[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tail[i];
            @(posedge clk);
            #1;
            check("post_rst_probe0", 32'(probe0), 32'd0);
            check("post_rst_probe1", 32'(probe1), 32'(tail[i]));
        end

        // Zero-length frame after reset
        tail = CK ? '{8'hA5, 8'h00, 8'h00} : '{8'hA5, 8'h00};
        nb = tail.size();
        for (int i = 0; i <= nb; i++) begin
            @(negedge clk);
            in_valid = (i < nb);
            in_data  = (i < nb) ? tail[i] : 8'h00;
            @(posedge clk);
            #1;
            check("zlen_frame_ok", 32'(frame_ok), 32'(i == nb));
            check("zlen_probe0", 32'(probe0), 32'(i < nb));
        end
        check("zlen_ok_cnt", 32'(ok_cnt), 32'd1);
        check("zlen_err_cnt", 32'(err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
